// File: rtl/scan_multichain_ctrl.sv
// Parallel muxed-D scan chains with an autonomous shift/capture/flush sequencer and MISR compaction.
// Acts as a plain register bank between logic cones when test_mode is low.
module scan_multichain_ctrl #(
    parameter int                NUM_CHAINS = 4,
    parameter int                CHAIN_LEN  = 53,
    parameter int                PAT_W      = 16,
    parameter int                MISR_W     = 16,
    parameter logic [MISR_W-1:0] MISR_POLY  = 16'h100B
) (
    input  logic                            Clk,
    input  logic                            Rst,
    input  logic                            test_mode,
    input  logic                            start,
    input  logic [PAT_W-1:0]                num_patterns,
    input  logic [NUM_CHAINS-1:0]           scan_in,
    input  logic                            si_valid,
    input  logic [NUM_CHAINS*CHAIN_LEN-1:0] func_d,
    output logic [NUM_CHAINS*CHAIN_LEN-1:0] state_q,
    output logic [NUM_CHAINS-1:0]           scan_out,
    output logic                            SE,
    output logic                            busy,
    output logic                            done,
    output logic [MISR_W-1:0]               misr_sig
);

    localparam int TOTAL = NUM_CHAINS * CHAIN_LEN;
    localparam int CNT_W = $clog2(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CAPTURE,
        ST_FLUSH,
        ST_DONE
    } fsm_t;

    fsm_t             fsm_state, fsm_next;
    logic [TOTAL-1:0] chain_q, chain_next, chain_shifted;
    logic [MISR_W-1:0] misr_q, misr_next, misr_step;
    logic [PAT_W-1:0] pat_cnt, pat_next;
    logic [CNT_W-1:0] shift_cnt, shift_next;
    logic             first_pat, first_next;
    logic [NUM_CHAINS-1:0] shift_bits;

    always_comb begin
        scan_out = '0;
        for (int c = 0; c < NUM_CHAINS; c++) begin
            scan_out[c] = chain_q[c*CHAIN_LEN + CHAIN_LEN - 1];
        end
    end

    // Flush drains the chains with zeros; normal shifting takes the tester bits.
    assign shift_bits = (fsm_state == ST_FLUSH) ? '0 : scan_in;

    always_comb begin
        chain_shifted = chain_q;
        for (int c = 0; c < NUM_CHAINS; c++) begin
            chain_shifted[c*CHAIN_LEN +: CHAIN_LEN] =
                {chain_q[c*CHAIN_LEN +: CHAIN_LEN-1], shift_bits[c]};
        end
    end

    // Compaction uses the pre-shift scan_out, i.e. the bit leaving each chain.
    assign misr_step = (misr_q << 1)
                     ^ (misr_q[MISR_W-1] ? MISR_POLY : '0)
                     ^ MISR_W'(scan_out);

    always_comb begin
        fsm_next   = fsm_state;
        chain_next = chain_q;
        misr_next  = misr_q;
        pat_next   = pat_cnt;
        shift_next = shift_cnt;
        first_next = first_pat;
        case (fsm_state)
            ST_IDLE: begin
                if (!test_mode) begin
                    chain_next = func_d;
                end else if (start) begin
                    misr_next  = '0;
                    first_next = 1'b1;
                    pat_next   = num_patterns;
                    shift_next = '0;
                    fsm_next   = (num_patterns != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (!test_mode) begin
                    fsm_next = ST_IDLE;
                end else if (si_valid) begin
                    chain_next = chain_shifted;
                    if (!first_pat) begin
                        misr_next = misr_step;
                    end
                    if (shift_cnt == LAST_SHIFT) begin
                        shift_next = '0;
                        fsm_next   = ST_CAPTURE;
                    end else begin
                        shift_next = shift_cnt + 1'b1;
                    end
                end
            end
            ST_CAPTURE: begin
                if (!test_mode) begin
                    fsm_next = ST_IDLE;
                end else begin
                    chain_next = func_d;
                    pat_next   = pat_cnt - 1'b1;
                    first_next = 1'b0;
                    fsm_next   = (pat_cnt == PAT_W'(1)) ? ST_FLUSH : ST_SHIFT;
                end
            end
            ST_FLUSH: begin
                if (!test_mode) begin
                    fsm_next = ST_IDLE;
                end else begin
                    chain_next = chain_shifted;
                    misr_next  = misr_step;
                    if (shift_cnt == LAST_SHIFT) begin
                        shift_next = '0;
                        fsm_next   = ST_DONE;
                    end else begin
                        shift_next = shift_cnt + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                fsm_next = ST_IDLE;
            end
            default: begin
                fsm_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            fsm_state <= ST_IDLE;
            chain_q   <= '0;
            misr_q    <= '0;
            pat_cnt   <= '0;
            shift_cnt <= '0;
            first_pat <= 1'b1;
        end else begin
            fsm_state <= fsm_next;
            chain_q   <= chain_next;
            misr_q    <= misr_next;
            pat_cnt   <= pat_next;
            shift_cnt <= shift_next;
            first_pat <= first_next;
        end
    end

    assign state_q  = chain_q;
    assign misr_sig = misr_q;
    assign SE       = (fsm_state == ST_SHIFT) || (fsm_state == ST_FLUSH);
    assign busy     = (fsm_state != ST_IDLE);
    assign done     = (fsm_state == ST_DONE);

endmodule

// File: tb/tb_scan_multichain_ctrl.sv
// Bench for scan_multichain_ctrl: directed scenarios with literal expectations, then random traffic
// checked every cycle against a chain/queue-level reference model.
module tb_scan_multichain_ctrl;

    localparam int NC = 2;
    localparam int CL = 4;
    localparam int PW = 16;
    localparam int MW = 16;
    localparam logic [MW-1:0] POLY = 16'h100B;

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_CAP   = 2;
    localparam int M_FLUSH = 3;
    localparam int M_FIN   = 4;

    logic              Clk = 1'b0;
    logic              Rst = 1'b0;
    logic              test_mode = 1'b0;
    logic              start = 1'b0;
    logic [PW-1:0]     num_patterns = '0;
    logic [NC-1:0]     scan_in = '0;
    logic              si_valid = 1'b0;
    logic [NC*CL-1:0]  func_d = '0;
    logic [NC*CL-1:0]  state_q;
    logic [NC-1:0]     scan_out;
    logic              SE;
    logic              busy;
    logic              done;
    logic [MW-1:0]     misr_sig;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    logic [CL-1:0] m_chain [NC];
    logic [MW-1:0] m_sig;
    int            m_phase;
    int            m_left;
    int            m_shifts;
    bit            m_first;

    scan_multichain_ctrl #(
        .NUM_CHAINS(NC),
        .CHAIN_LEN (CL),
        .PAT_W     (PW),
        .MISR_W    (MW),
        .MISR_POLY (POLY)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .test_mode   (test_mode),
        .start       (start),
        .num_patterns(num_patterns),
        .scan_in     (scan_in),
        .si_valid    (si_valid),
        .func_d      (func_d),
        .state_q     (state_q),
        .scan_out    (scan_out),
        .SE          (SE),
        .busy        (busy),
        .done        (done),
        .misr_sig    (misr_sig)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Signature polynomial arithmetic: multiply by x modulo POLY, then add the incoming bits.
    function automatic logic [MW-1:0] sig_step(input logic [MW-1:0] s, input logic [NC-1:0] bits_in);
        logic [MW-1:0] r;
        r = s << 1;
        if (s[MW-1]) r = r ^ POLY;
        r = r ^ MW'(bits_in);
        return r;
    endfunction

    function automatic logic [NC*CL-1:0] m_pack();
        logic [NC*CL-1:0] v;
        for (int c = 0; c < NC; c++) v[c*CL +: CL] = m_chain[c];
        return v;
    endfunction

    function automatic logic [NC-1:0] m_out();
        logic [NC-1:0] v;
        for (int c = 0; c < NC; c++) v[c] = m_chain[c][CL-1];
        return v;
    endfunction

    always @(posedge Clk or posedge Rst) begin : ref_model
        logic [CL-1:0] ch [NC];
        logic [MW-1:0] sig;
        logic [NC-1:0] leaving;
        int  phase, left, shifts;
        bit  first;
        ch = m_chain; sig = m_sig; phase = m_phase; left = m_left;
        shifts = m_shifts; first = m_first;
        leaving = m_out();
        if (Rst) begin
            for (int c = 0; c < NC; c++) ch[c] = '0;
            sig = '0; phase = M_IDLE; left = 0; shifts = 0; first = 1'b1;
        end else if (phase != M_IDLE && phase != M_FIN && !test_mode) begin
            phase = M_IDLE;
        end else begin
            case (phase)
                M_IDLE: begin
                    if (!test_mode) begin
                        for (int c = 0; c < NC; c++) ch[c] = func_d[c*CL +: CL];
                    end else if (start) begin
                        sig = '0; first = 1'b1; left = int'(num_patterns); shifts = 0;
                        phase = (left == 0) ? M_FIN : M_LOAD;
                    end
                end
                M_LOAD: begin
                    if (si_valid) begin
                        for (int c = 0; c < NC; c++) ch[c] = {ch[c][CL-2:0], scan_in[c]};
                        if (!first) sig = sig_step(sig, leaving);
                        shifts++;
                        if (shifts == CL) begin shifts = 0; phase = M_CAP; end
                    end
                end
                M_CAP: begin
                    for (int c = 0; c < NC; c++) ch[c] = func_d[c*CL +: CL];
                    left--; first = 1'b0;
                    phase = (left == 0) ? M_FLUSH : M_LOAD;
                end
                M_FLUSH: begin
                    for (int c = 0; c < NC; c++) ch[c] = {ch[c][CL-2:0], 1'b0};
                    sig = sig_step(sig, leaving);
                    shifts++;
                    if (shifts == CL) begin shifts = 0; phase = M_FIN; end
                end
                default: phase = M_IDLE;
            endcase
        end
        m_chain <= ch; m_sig <= sig; m_phase <= phase; m_left <= left;
        m_shifts <= shifts; m_first <= first;
    end

    always @(negedge Clk) begin
        if (cmp_en) begin
            check("state_q", 64'(state_q), 64'(m_pack()));
            check("scan_out", 64'(scan_out), 64'(m_out()));
            check("SE", 64'(SE), 64'(m_phase == M_LOAD || m_phase == M_FLUSH));
            check("busy", 64'(busy), 64'(m_phase != M_IDLE));
            check("done", 64'(done), 64'(m_phase == M_FIN));
            check("misr_sig", 64'(misr_sig), 64'(m_sig));
        end
    end

    task automatic kick(input logic [PW-1:0] n);
        test_mode = 1'b1; start = 1'b1; num_patterns = n;
        @(negedge Clk);
        start = 1'b0;
    endtask

    task automatic run_to_done(input int budget);
        int n = 0;
        si_valid = 1'b1;
        while (done !== 1'b1 && n < budget) begin
            scan_in = NC'($urandom);
            @(negedge Clk);
            n++;
        end
        check("done_within_budget", 64'(n < budget), 64'(1));
    endtask

    initial begin
        logic [CL-1:0] ld0, ld1, fl0, fl1;
        int n;
        ld0 = 4'b1011; ld1 = 4'b0010;
        fl0 = 4'b1100; fl1 = 4'b0011;

        #1 Rst = 1'b1;
        @(negedge Clk);
        check("rst_state_q", 64'(state_q), 64'(0));
        check("rst_misr", 64'(misr_sig), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_SE", 64'(SE), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        cmp_en = 1'b1;
        @(negedge Clk);
        #2 Rst = 1'b0;

        // Functional register bank
        func_d = 8'hA5; test_mode = 1'b0;
        @(negedge Clk);
        check("func_state_q", 64'(state_q), 64'(8'hA5));
        check("func_SE", 64'(SE), 64'(0));
        check("func_busy", 64'(busy), 64'(0));

        // One pattern: load, capture 8'h3C, flush
        func_d = 8'h3C;
        kick(16'd1);
        si_valid = 1'b1;
        for (int k = 0; k < CL; k++) begin
            scan_in = {ld1[CL-1-k], ld0[CL-1-k]};
            @(negedge Clk);
        end
        si_valid = 1'b0;
        check("load_state_q", 64'(state_q), 64'(8'h2B));
        check("load_misr", 64'(misr_sig), 64'(0));
        check("capture_SE", 64'(SE), 64'(0));
        @(negedge Clk);
        for (int k = 0; k < CL; k++) begin
            check("flush_so0", 64'(scan_out[0]), 64'(fl0[CL-1-k]));
            check("flush_so1", 64'(scan_out[1]), 64'(fl1[CL-1-k]));
            check("flush_SE", 64'(SE), 64'(1));
            @(negedge Clk);
        end
        check("done_pulse", 64'(done), 64'(1));
        check("golden_misr", 64'(misr_sig), 64'(16'h000A));
        @(negedge Clk);
        check("done_cleared", 64'(done), 64'(0));
        check("idle_busy", 64'(busy), 64'(0));

        // All-zero capture leaves the signature at zero
        func_d = '0;
        kick(16'd1);
        run_to_done(40);
        check("zero_misr", 64'(misr_sig), 64'(0));
        @(negedge Clk);

        // Stall mid-shift: counters hold, SE stays high
        func_d = 8'h96;
        kick(16'd2);
        si_valid = 1'b1;
        repeat (2) begin scan_in = NC'($urandom); @(negedge Clk); end
        si_valid = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            check("stall_SE", 64'(SE), 64'(1));
        end
        si_valid = 1'b1;
        repeat (2) begin scan_in = NC'($urandom); @(negedge Clk); end
        check("stall_capture_SE", 64'(SE), 64'(0));
        check("stall_capture_busy", 64'(busy), 64'(1));
        run_to_done(60);
        @(negedge Clk);

        // Zero patterns
        kick(16'd0);
        check("zero_done", 64'(done), 64'(1));
        check("zero_SE", 64'(SE), 64'(0));
        @(negedge Clk);
        check("zero_idle", 64'(busy), 64'(0));

        // Abort during shift
        kick(16'd1);
        si_valid = 1'b1;
        repeat (2) begin scan_in = NC'($urandom); @(negedge Clk); end
        test_mode = 1'b0;
        @(negedge Clk);
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_SE", 64'(SE), 64'(0));
        @(negedge Clk);

        // Reset asserted mid-flush acts without a clock edge
        func_d = 8'hE7;
        kick(16'd2);
        si_valid = 1'b1;
        n = 0;
        while (m_phase != M_FLUSH && n < 100) begin
            scan_in = NC'($urandom); @(negedge Clk); n++;
        end
        check("reach_flush", 64'(n < 100), 64'(1));
        @(negedge Clk);
        #2 Rst = 1'b1;
        #1;
        check("async_rst_state_q", 64'(state_q), 64'(0));
        check("async_rst_misr", 64'(misr_sig), 64'(0));
        check("async_rst_busy", 64'(busy), 64'(0));
        #1 Rst = 1'b0;
        @(negedge Clk);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if (test_mode) test_mode = ($urandom_range(0, 99) >= 2);
            else           test_mode = ($urandom_range(0, 1) == 1);
            start        = ($urandom_range(0, 7) == 0);
            num_patterns = PW'($urandom_range(0, 3));
            scan_in      = NC'($urandom);
            si_valid     = ($urandom_range(0, 3) != 0);
            func_d       = (NC*CL)'($urandom);
            @(negedge Clk);
        end
        start = 1'b0; test_mode = 1'b0;
        repeat (3) @(negedge Clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
